conv_mem_responder: RTL and testbench

- Word-addressed memory responder that sits on the far side of the CONV bus bridge.
- Serves R_req/addr/W_req/W_data accesses and returns R_data.
- Holds the image region and all layer buffers in one flat 2^ADDR_W-word array. Default map: image at words 0-4095, layer buffers at words 4096-16383.
- Zero-clears its array after reset, then asserts ready to start the CONV engine.

---
 rtl/conv_mem_responder_if.sv | 38 +++
 rtl/conv_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_conv_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mem_responder_if
//  Description : Bus bundle between the CONV bus bridge (master) and the
//                word-addressed memory responder (slave).
//  Signals     : R_req   - read request
//                addr    - byte address
//                W_req   - per-byte write enables
//                W_data  - write data
//                R_data  - read data (valid with rvalid)
//                rvalid  - read data valid strobe
//                ready   - memory cleared and usable
//                err     - one-cycle illegal-access pulse
//                err_cnt - saturating illegal-access count
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_mem_responder_if;
   logic        R_req;
   logic [31:0] addr;
   logic [3:0]  W_req;
   logic [31:0] W_data;
   logic [31:0] R_data;
   logic        rvalid;
   logic        ready;
   logic        err;
   logic [15:0] err_cnt;

   modport master (
      output R_req, addr, W_req, W_data,
      input  R_data, rvalid, ready, err, err_cnt
   );

   modport slave (
      input  R_req, addr, W_req, W_data,
      output R_data, rvalid, ready, err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mem_responder
//  Description : Word-addressed memory responder behind the CONV bus bridge.
//                One flat 2^ADDR_W-word array holds the image and all layer
//                buffers. After reset the array is zero-cleared, then ready
//                is raised. Reads are fully pipelined with READ_LAT cycles of
//                latency; writes use per-byte enables.
//  Ports       : clk - system clock, rising edge
//                rst - asynchronous active-low reset
//                bus - conv_mem_responder_if.slave (request/response bundle)
//  Parameters  : ADDR_W (word-address width), READ_LAT (1..4),
//                CLEAR_ON_RESET (1 = zero-clear sweep after reset)
//  Macro       : MEM_ERRCNT_EN - builds the saturating illegal-access
//                counter; when undefined err_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_responder #(
   parameter int ADDR_W         = 14,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   conv_mem_responder_if.slave   bus
);

   localparam int               c_depth     = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  c_clr_last  = (ADDR_W+1)'(c_depth - 1);

   localparam logic [0:0] c_st_clear = 1'b0;
   localparam logic [0:0] c_st_ready = 1'b1;
   localparam logic [0:0] c_st_reset = (CLEAR_ON_RESET != 0) ? c_st_clear : c_st_ready;

   logic [0:0]        r_state;
   logic [0:0]        w_next_state;
   logic              r_ready;
   logic              w_ready_nxt;
   logic              w_clr_we;
   logic              w_clr_last;
   logic [ADDR_W:0]   r_clr_cnt;

   logic [31:0]       r_mem [c_depth];

   logic [ADDR_W-1:0] w_idx;
   logic              w_legal;
   logic              w_req_any;
   logic              w_wr_en;
   logic [31:0]       w_rd_data;
   logic              r_err;

   logic [READ_LAT-1:0] r_pipe_vld;
   logic [31:0]         r_pipe_dat [READ_LAT];

   // ---------------------------------------------------------------- decode
   assign w_idx     = bus.addr[ADDR_W+1:2];
   assign w_legal   = r_ready && (bus.addr[1:0] == 2'b00) && (bus.addr[31:ADDR_W+2] == '0);
   assign w_req_any = bus.R_req || (bus.W_req != 4'b0000);
   assign w_wr_en   = w_legal && (bus.W_req != 4'b0000);
   // Illegal reads still return a beat, carrying zero instead of array data.
   assign w_rd_data = w_legal ? r_mem[w_idx] : 32'h0;
   assign w_clr_last = (r_clr_cnt == c_clr_last);

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_reset;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= w_ready_nxt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_clear: if (w_clr_last) w_next_state = c_st_ready;
         c_st_ready: w_next_state = c_st_ready;
         default:    w_next_state = c_st_clear;
      endcase
   end

   // ready is registered from the next state so it rises on the same edge
   // the FSM enters READY, yet stays low while reset is held.
   always_comb begin
      w_clr_we    = (r_state == c_st_clear);
      w_ready_nxt = (w_next_state == c_st_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_cnt <= '0;
      end else if (w_clr_we) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
      end
   end

   // ----------------------------------------------------------------- array
   // No reset on the storage itself; the clear sweep provides defined
   // contents. Accesses are illegal during CLEAR, so the two write sources
   // never compete.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt[ADDR_W-1:0]] <= 32'h0;
      end else if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.W_req[b]) r_mem[w_idx][8*b +: 8] <= bus.W_data[8*b +: 8];
         end
      end
   end

   // --------------------------------------------------------- read pipeline
   // Stage 0 samples the array on the request edge, so a same-cycle write
   // is not visible to that read. Data stages only load on a valid beat,
   // which makes the output stage hold its last value between beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < READ_LAT; i++) r_pipe_dat[i] <= 32'h0;
      end else begin
         r_pipe_vld[0] <= bus.R_req;
         if (bus.R_req) r_pipe_dat[0] <= w_rd_data;
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            if (r_pipe_vld[i-1]) r_pipe_dat[i] <= r_pipe_dat[i-1];
         end
      end
   end

   // ------------------------------------------------------------ error path
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_req_any && !w_legal;
      end
   end

`ifdef MEM_ERRCNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt <= 16'h0;
      end else if (r_err && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'h1;
      end
   end

   assign bus.err_cnt = r_err_cnt;
`else
   assign bus.err_cnt = 16'h0;
`endif

   // --------------------------------------------------------------- outputs
   assign bus.R_data = r_pipe_dat[READ_LAT-1];
   assign bus.rvalid = r_pipe_vld[READ_LAT-1];
   assign bus.ready  = r_ready;
   assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_mem_responder
//  Description : Self-checking bench for conv_mem_responder. Two instances
//                (READ_LAT=1 and READ_LAT=3) receive identical stimulus.
//                Expected read beats, with their due cycle, are queued when
//                a read is issued and checked when rvalid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mem_responder;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t q1[$];
   exp_t q3[$];

   conv_mem_responder_if b1 ();
   conv_mem_responder_if b3 ();

   conv_mem_responder #(.ADDR_W(14), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk (clk),
      .rst (rst_n),
      .bus (b1)
   );

   conv_mem_responder #(.ADDR_W(14), .READ_LAT(3), .CLEAR_ON_RESET(1)) u_dut3 (
      .clk (clk),
      .rst (rst_n),
      .bus (b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request cycle on both instances, then return the bus to idle.
   task automatic req(input logic re, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input logic push, input logic [31:0] exp);
      b1.R_req = re;  b3.R_req = re;
      b1.addr  = a;   b3.addr  = a;
      b1.W_req = we;  b3.W_req = we;
      b1.W_data = wd; b3.W_data = wd;
      if (re && push) begin
         q1.push_back('{d: exp, due: cyc + 1});
         q3.push_back('{d: exp, due: cyc + 3});
      end
      @(posedge clk); #1;
      b1.R_req = 1'b0;  b3.R_req = 1'b0;
      b1.addr  = 32'h0; b3.addr  = 32'h0;
      b1.W_req = 4'h0;  b3.W_req = 4'h0;
      b1.W_data = 32'h0; b3.W_data = 32'h0;
   endtask

   task automatic wait_ready(input int n0, input string tag);
      int t1;
      int t3;
      t1 = -1;
      t3 = -1;
      for (int k = 0; k < 20000 && (t1 < 0 || t3 < 0); k++) begin
         @(negedge clk);
         if (b1.ready && t1 < 0) t1 = cyc - n0;
         if (b3.ready && t3 < 0) t3 = cyc - n0;
      end
      chk({tag, "_lat1"}, 32'(t1), 32'd16384);
      chk({tag, "_lat3"}, 32'(t3), 32'd16384);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   // Response monitors: every rvalid must match the oldest expected beat at
   // exactly its due cycle; an overdue beat counts as missing.
   always @(negedge clk) begin
      if (b1.rvalid) begin
         if (q1.size() == 0) begin
            chk("spurious_rvalid_lat1", {31'h0, b1.rvalid}, 32'h0);
         end else begin
            chk("rdata_lat1", b1.R_data, q1[0].d);
            chk("rtime_lat1", 32'(cyc), 32'(q1[0].due));
            void'(q1.pop_front());
         end
      end else if (q1.size() != 0 && cyc >= q1[0].due) begin
         chk("missing_rvalid_lat1", {31'h0, b1.rvalid}, 32'h1);
         void'(q1.pop_front());
      end
   end

   always @(negedge clk) begin
      if (b3.rvalid) begin
         if (q3.size() == 0) begin
            chk("spurious_rvalid_lat3", {31'h0, b3.rvalid}, 32'h0);
         end else begin
            chk("rdata_lat3", b3.R_data, q3[0].d);
            chk("rtime_lat3", 32'(cyc), 32'(q3[0].due));
            void'(q3.pop_front());
         end
      end else if (q3.size() != 0 && cyc >= q3[0].due) begin
         chk("missing_rvalid_lat3", {31'h0, b3.rvalid}, 32'h1);
         void'(q3.pop_front());
      end
   end

   initial begin
      int          n0;
      logic [15:0] exp_cnt;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      b1.R_req = 1'b0;  b3.R_req = 1'b0;
      b1.addr  = 32'h0; b3.addr  = 32'h0;
      b1.W_req = 4'h0;  b3.W_req = 4'h0;
      b1.W_data = 32'h0; b3.W_data = 32'h0;
`ifdef MEM_ERRCNT_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif

      // Reset state
      idle(3);
      chk("rst_ready",  {31'h0, b1.ready},  32'h0);
      chk("rst_rvalid", {31'h0, b3.rvalid}, 32'h0);
      chk("rst_err",    {31'h0, b1.err},    32'h0);
      chk("rst_rdata",  b1.R_data,          32'h0);
      chk("rst_errcnt", {16'h0, b1.err_cnt}, 32'h0);

      // Release reset; a read during CLEAR is illegal and returns zero
      rst_n = 1'b1;
      n0 = cyc;
      req(1'b1, 32'h0000_0000, 4'h0, 32'h0, 1'b1, 32'h0);
      chk("err_in_clear_lat1", {31'h0, b1.err}, 32'h1);
      chk("err_in_clear_lat3", {31'h0, b3.err}, 32'h1);
      wait_ready(n0, "clear_len");

      // Top word of the array reads back cleared
      req(1'b1, 32'h0000_FFFC, 4'h0, 32'h0, 1'b1, 32'h0);
      chk("err_low_legal", {31'h0, b1.err}, 32'h0);

      // Full write then read back
      req(1'b0, 32'h0000_4000, 4'hF, 32'h000A_BCDE, 1'b0, 32'h0);
      req(1'b1, 32'h0000_4000, 4'h0, 32'h0, 1'b1, 32'h000A_BCDE);

      // Partial write over an existing word
      req(1'b0, 32'h0000_4004, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
      req(1'b0, 32'h0000_4004, 4'b0101, 32'hAABB_CCDD, 1'b0, 32'h0);
      req(1'b1, 32'h0000_4004, 4'h0, 32'h0, 1'b1, 32'h11BB_33DD);

      // Back-to-back reads of words 0..3
      for (int i = 0; i < 4; i++) req(1'b0, 32'(4*i), 4'hF, 32'(i+1), 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) req(1'b1, 32'(4*i), 4'h0, 32'h0, 1'b1, 32'(i+1));
      idle(4);

      // Same-cycle read and write of word 5: read sees old data
      req(1'b0, 32'h0000_0014, 4'hF, 32'd7, 1'b0, 32'h0);
      req(1'b1, 32'h0000_0014, 4'hF, 32'd9, 1'b1, 32'd7);
      req(1'b1, 32'h0000_0014, 4'h0, 32'h0, 1'b1, 32'd9);
      idle(4);
      chk("hold_rdata_lat1", b1.R_data, 32'd9);
      chk("hold_rdata_lat3", b3.R_data, 32'd9);

      // Out-of-range read and misaligned write are both illegal
      req(1'b1, 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0);
      chk("err_oob_read", {31'h0, b1.err}, 32'h1);
      req(1'b0, 32'h0000_0002, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
      chk("err_misaligned_write", {31'h0, b3.err}, 32'h1);
      req(1'b1, 32'h0000_0000, 4'h0, 32'h0, 1'b1, 32'd1);
      chk("err_clears", {31'h0, b1.err}, 32'h0);
      idle(4);
      chk("err_cnt_lat1", {16'h0, b1.err_cnt}, {16'h0, exp_cnt});
      chk("err_cnt_lat3", {16'h0, b3.err_cnt}, {16'h0, exp_cnt});

      // Reset with a read in flight: the beat is dropped, CLEAR restarts
      req(1'b1, 32'h0000_4000, 4'h0, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b0;
      idle(4);
      chk("midrst_ready", {31'h0, b3.ready}, 32'h0);
      chk("midrst_errcnt", {16'h0, b1.err_cnt}, 32'h0);
      rst_n = 1'b1;
      n0 = cyc;
      wait_ready(n0, "reclear_len");
      req(1'b1, 32'h0000_4000, 4'h0, 32'h0, 1'b1, 32'h0);
      req(1'b1, 32'h0000_0014, 4'h0, 32'h0, 1'b1, 32'h0);
      idle(6);

      chk("queue_empty_lat1", 32'(q1.size()), 32'h0);
      chk("queue_empty_lat3", 32'(q3.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
